// File: rtl/muldiv_unit.sv
// muldiv_unit: multiply/divide unit with HI/LO result registers.
// Multiply completes in one cycle; divide runs one restoring step per cycle.
//
// state | meaning
// IDLE  | ready; accepts start or HI/LO writes
// MUL   | product written into {hi,lo}
// DIV   | restoring division on magnitudes, one quotient bit per cycle
// FIN   | sign fix-up and result write (no write on divide-by-zero)
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             start,
  input  logic             div,
  input  logic             unsigned_op,
  input  logic             write_hi,
  input  logic             write_lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, b_q, b_mag, quo, rem;
  logic             uns_q, a_neg, b_neg, dz_q;

  logic             op1_neg, op2_neg;
  logic [WIDTH-1:0] op1_mag, op2_mag;

  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [WIDTH:0]     shifted, diff;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign op1_neg = !unsigned_op && op1[WIDTH-1];
  assign op2_neg = !unsigned_op && op2[WIDTH-1];
  assign op1_mag = op1_neg ? -op1 : op1;
  assign op2_mag = op2_neg ? -op2 : op2;

  // Extending to 2*WIDTH makes one unsigned multiply serve both modes.
  assign ext_a = {{WIDTH{!uns_q && a_q[WIDTH-1]}}, a_q};
  assign ext_b = {{WIDTH{!uns_q && b_q[WIDTH-1]}}, b_q};
  assign prod  = ext_a * ext_b;

  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, b_mag};
  assign q_fix   = (a_neg ^ b_neg) ? -quo : quo;
  assign r_fix   = a_neg ? -rem : rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (!div)           state_nxt = MUL;
          else if (op2 == '0) state_nxt = FIN;
          else                state_nxt = DIV;
        end
      end
      MUL:     state_nxt = IDLE;
      DIV:     if (cnt == '0) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      b_mag       <= '0;
      quo         <= '0;
      rem         <= '0;
      uns_q       <= 1'b0;
      a_neg       <= 1'b0;
      b_neg       <= 1'b0;
      dz_q        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= op1;
            b_q   <= op2;
            uns_q <= unsigned_op;
            a_neg <= op1_neg;
            b_neg <= op2_neg;
            b_mag <= op2_mag;
            quo   <= op1_mag;
            rem   <= '0;
            dz_q  <= div && (op2 == '0);
            cnt   <= CW'(WIDTH - 1);
          end else begin
            if (write_hi) hi <= op1;
            if (write_lo) lo <= op1;
          end
        end
        MUL: begin
          {hi, lo} <= prod;
          done     <= 1'b1;
        end
        DIV: begin
          if (!diff[WIDTH]) begin
            rem <= diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIN: begin
          done        <= 1'b1;
          div_by_zero <= dz_q;
          if (!dz_q) begin
            hi <= r_fix;
            lo <= q_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: WIDTH=32 and WIDTH=8 instances,
// directed cases plus random operands against an arithmetic reference model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] op1_32 = '0, op2_32 = '0, hi32, lo32;
  logic        st32 = 0, dv32 = 0, un32 = 0, wh32 = 0, wl32 = 0;
  logic        busy32, done32, dz32;
  logic [7:0]  op1_8 = '0, op2_8 = '0, hi8, lo8;
  logic        st8 = 0, dv8 = 0, un8 = 0, wh8 = 0, wl8 = 0;
  logic        busy8, done8, dz8;

  int n_chk = 0;
  int n_err = 0;
  longint unsigned eh[2];
  longint unsigned el[2];

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .op1(op1_32), .op2(op2_32), .start(st32),
    .div(dv32), .unsigned_op(un32), .write_hi(wh32), .write_lo(wl32),
    .busy(busy32), .done(done32), .div_by_zero(dz32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .op1(op1_8), .op2(op2_8), .start(st8),
    .div(dv8), .unsigned_op(un8), .write_hi(wh8), .write_lo(wl8),
    .busy(busy8), .done(done8), .div_by_zero(dz8), .hi(hi8), .lo(lo8)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint unsigned mask_of(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint unsigned rnd(input int w);
    longint unsigned m, msb;
    m   = mask_of(w);
    msb = 64'd1 << (w - 1);
    case ($urandom_range(0, 9))
      0:       return 64'd0;
      1:       return msb;
      2:       return m;
      3:       return 64'd1;
      4:       return msb - 64'd1;
      default: return longint'({$urandom(), $urandom()}) & m;
    endcase
  endfunction

  // Reference: plain integer arithmetic on sign-interpreted operands.
  function automatic void model(input int w, input bit dv, input bit un,
                                input longint unsigned a, input longint unsigned b,
                                inout longint unsigned nh, inout longint unsigned nl,
                                output bit edz);
    longint unsigned m, msb, p;
    longint sa, sb, q, r;
    m   = mask_of(w);
    msb = 64'd1 << (w - 1);
    sa  = un ? longint'(a) : (longint'(a ^ msb) - longint'(msb));
    sb  = un ? longint'(b) : (longint'(b ^ msb) - longint'(msb));
    edz = 1'b0;
    if (!dv) begin
      if (un) p = a * b;
      else    p = longint'(sa * sb);
      nl = p & m;
      nh = (p >> w) & m;
    end else if (b == 0) begin
      edz = 1'b1;
    end else begin
      if (un) begin
        q = longint'(a / b);
        r = longint'(a % b);
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
      nl = longint'(q) & m;
      nh = longint'(r) & m;
    end
  endfunction

  task automatic set_in(input int w, input bit st, input bit dv, input bit un,
                        input longint unsigned a, input longint unsigned b,
                        input bit wh, input bit wl);
    if (w == 32) begin
      st32 = st; dv32 = dv; un32 = un; op1_32 = a[31:0]; op2_32 = b[31:0];
      wh32 = wh; wl32 = wl;
    end else begin
      st8 = st; dv8 = dv; un8 = un; op1_8 = a[7:0]; op2_8 = b[7:0];
      wh8 = wh; wl8 = wl;
    end
  endtask

  function automatic logic [63:0] o_hi(input int w);
    return (w == 32) ? {32'b0, hi32} : {56'b0, hi8};
  endfunction
  function automatic logic [63:0] o_lo(input int w);
    return (w == 32) ? {32'b0, lo32} : {56'b0, lo8};
  endfunction
  function automatic logic o_busy(input int w);
    return (w == 32) ? busy32 : busy8;
  endfunction
  function automatic logic o_done(input int w);
    return (w == 32) ? done32 : done8;
  endfunction
  function automatic logic o_dz(input int w);
    return (w == 32) ? dz32 : dz8;
  endfunction

  // stray: 0 none, 1 start pulse mid-operation, 2 write_lo pulse mid-operation.
  // now: drive start in the current (done) cycle instead of waiting a cycle.
  task automatic do_op(input int w, input bit dv, input bit un,
                       input longint unsigned a, input longint unsigned b,
                       input int stray, input bit now, input bit wr_st,
                       output int nbusy);
    int idx, lat, exp_lat;
    bit edz;
    longint unsigned nh, nl;
    idx = (w == 32) ? 0 : 1;
    if (!now) begin
      @(negedge clk);
      check_eq("done_pulse_width", 64'(o_done(w)), 64'd0);
    end
    set_in(w, 1'b1, dv, un, a, b, wr_st, wr_st);
    nh = eh[idx];
    nl = el[idx];
    model(w, dv, un, a, b, nh, nl, edz);
    exp_lat = (!dv || b == 0) ? 1 : w + 1;
    @(posedge clk);
    lat   = -1;
    nbusy = 0;
    for (int i = 0; i < w + 8 && lat < 0; i++) begin
      @(negedge clk);
      if (i == 0)
        set_in(w, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               rnd(w), rnd(w), 1'b0, 1'b0);
      if (i == 5 && stray == 1) set_in(w, 1'b1, 1'b0, 1'b1, rnd(w), rnd(w), 1'b0, 1'b0);
      if (i == 5 && stray == 2) set_in(w, 1'b0, 1'b0, 1'b0, rnd(w), rnd(w), 1'b0, 1'b1);
      if (i == 6 && stray != 0) set_in(w, 1'b0, 1'b0, 1'b0, rnd(w), rnd(w), 1'b0, 1'b0);
      if (o_busy(w)) nbusy++;
      if (o_done(w)) lat = i;
      else check_eq("dz_without_done", 64'(o_dz(w)), 64'd0);
    end
    check_eq("done_latency", 64'(lat), 64'(exp_lat));
    check_eq("hi", o_hi(w), nh);
    check_eq("lo", o_lo(w), nl);
    check_eq("div_by_zero", 64'(o_dz(w)), 64'(edz));
    eh[idx] = nh;
    el[idx] = nl;
  endtask

  task automatic do_write(input int w, input bit wh, input bit wl, input longint unsigned v);
    int idx;
    idx = (w == 32) ? 0 : 1;
    @(negedge clk);
    set_in(w, 1'b0, 1'b0, 1'b0, v, 64'd0, wh, wl);
    @(posedge clk);
    if (wh) eh[idx] = v & mask_of(w);
    if (wl) el[idx] = v & mask_of(w);
    @(negedge clk);
    set_in(w, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    check_eq("write_hi", o_hi(w), eh[idx]);
    check_eq("write_lo", o_lo(w), el[idx]);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, ndone;
    eh[0] = 0; el[0] = 0; eh[1] = 0; el[1] = 0;

    #12;
    check_eq("rst_busy32", 64'(busy32), 64'd0);
    check_eq("rst_done32", 64'(done32), 64'd0);
    check_eq("rst_dz32", 64'(dz32), 64'd0);
    check_eq("rst_hi32", 64'(hi32), 64'd0);
    check_eq("rst_lo32", 64'(lo32), 64'd0);
    check_eq("rst_busy8", 64'(busy8), 64'd0);
    check_eq("rst_hi8", 64'(hi8), 64'd0);
    check_eq("rst_lo8", 64'(lo8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed multiply and divide at WIDTH=32.
    do_op(32, 1'b0, 1'b0, 64'hFFFFFFFE, 64'h3, 0, 1'b0, 1'b0, nb);
    check_eq("smul_hi_const", o_hi(32), 64'hFFFFFFFF);
    check_eq("smul_lo_const", o_lo(32), 64'hFFFFFFFA);
    do_op(32, 1'b0, 1'b1, 64'hFFFFFFFE, 64'h3, 0, 1'b0, 1'b0, nb);
    check_eq("umul_hi_const", o_hi(32), 64'h2);
    check_eq("umul_lo_const", o_lo(32), 64'hFFFFFFFA);
    do_op(32, 1'b1, 1'b0, 64'hFFFFFFF9, 64'h2, 0, 1'b0, 1'b0, nb);
    check_eq("sdiv_lo_const", o_lo(32), 64'hFFFFFFFD);
    check_eq("sdiv_hi_const", o_hi(32), 64'hFFFFFFFF);
    check_eq("sdiv_busy_cycles", 64'(nb), 64'd33);
    do_op(32, 1'b1, 1'b1, 64'h80000000, 64'hFFFFFFFF, 0, 1'b0, 1'b0, nb);
    check_eq("udiv_lo_const", o_lo(32), 64'h0);
    check_eq("udiv_hi_const", o_hi(32), 64'h80000000);

    // Writes, divide by zero, write while busy.
    do_write(32, 1'b1, 1'b0, 64'h1234);
    do_write(32, 1'b0, 1'b1, 64'h5678);
    do_op(32, 1'b1, 1'b0, 64'h99, 64'h0, 0, 1'b0, 1'b0, nb);
    check_eq("dz_hi_kept", o_hi(32), 64'h1234);
    check_eq("dz_lo_kept", o_lo(32), 64'h5678);
    check_eq("dz_flag", 64'(dz32), 64'd1);
    do_op(32, 1'b1, 1'b1, 64'd1000, 64'd7, 2, 1'b0, 1'b0, nb);

    // Overflow case, ignored mid-divide start, back-to-back start.
    do_op(32, 1'b1, 1'b0, 64'h80000000, 64'hFFFFFFFF, 1, 1'b0, 1'b0, nb);
    check_eq("ovf_lo_const", o_lo(32), 64'h80000000);
    check_eq("ovf_hi_const", o_hi(32), 64'h0);
    @(negedge clk);
    check_eq("no_queued_start", 64'(busy32), 64'd0);
    do_op(32, 1'b0, 1'b0, 64'h7, 64'hFFFFFFFB, 0, 1'b0, 1'b0, nb);
    do_op(32, 1'b1, 1'b0, 64'hFFFFFF00, 64'h10, 0, 1'b1, 1'b0, nb);

    // Writes dropped when coinciding with start; both writes together.
    do_op(32, 1'b0, 1'b1, 64'h10, 64'h20, 0, 1'b0, 1'b1, nb);
    do_write(32, 1'b1, 1'b1, 64'hA5A5A5A5);

    // Reset in the middle of a divide.
    @(negedge clk);
    set_in(32, 1'b1, 1'b1, 1'b0, 64'h12345678, 64'h5, 1'b0, 1'b0);
    @(posedge clk);
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i == 0) set_in(32, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", 64'(busy32), 64'd0);
    check_eq("abort_hi", 64'(hi32), 64'd0);
    check_eq("abort_lo", 64'(lo32), 64'd0);
    check_eq("abort_done", 64'(done32), 64'd0);
    eh[0] = 0; el[0] = 0; eh[1] = 0; el[1] = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done32 || done8) ndone++;
    end
    check_eq("no_done_after_abort", 64'(ndone), 64'd0);

    // Directed WIDTH=8 cases.
    do_op(8, 1'b0, 1'b0, 64'hFE, 64'h3, 0, 1'b0, 1'b0, nb);
    check_eq("smul8_hi_const", o_hi(8), 64'hFF);
    check_eq("smul8_lo_const", o_lo(8), 64'hFA);
    do_op(8, 1'b0, 1'b1, 64'hFE, 64'h3, 0, 1'b0, 1'b0, nb);
    check_eq("umul8_hi_const", o_hi(8), 64'h02);
    do_op(8, 1'b1, 1'b0, 64'hF9, 64'h2, 0, 1'b0, 1'b0, nb);
    check_eq("sdiv8_lo_const", o_lo(8), 64'hFD);
    check_eq("sdiv8_hi_const", o_hi(8), 64'hFF);
    check_eq("sdiv8_busy_cycles", 64'(nb), 64'd9);
    do_op(8, 1'b1, 1'b0, 64'h80, 64'hFF, 0, 1'b0, 1'b0, nb);
    check_eq("ovf8_lo_const", o_lo(8), 64'h80);

    // Random operands, all four modes, both widths.
    for (int mode = 0; mode < 4; mode++) begin
      for (int k = 0; k < 1500; k++)
        do_op(8, mode[1], mode[0], rnd(8), rnd(8), 0, 1'($urandom_range(0, 1)), 1'b0, nb);
      for (int k = 0; k < 150; k++)
        do_op(32, mode[1], mode[0], rnd(32), rnd(32), 0, 1'b0, 1'b0, nb);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
